// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed 7-segment display bus. It waits for
// each digit's pattern to hold steady, decodes it to BCD, and assembles the
// four digits into a frame.
//
// Handshake: there is no back-pressure. digit_strobe, code_err and
// frame_valid are single-cycle pulses. digit_idx and digit_bcd are meaningful
// only in a cycle where digit_strobe or code_err is high. bcd_value holds its
// value until the next frame_valid pulse.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  dig_en,
   output logic        digit_strobe,
   output logic [1:0]  digit_idx,
   output logic [3:0]  digit_bcd,
   output logic        code_err,
   output logic        frame_valid,
   output logic [15:0] bcd_value,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_BLANK    = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_CAPTURED = 2'd2
   } state_t;

   // Counter value one edge before the capture edge.
   localparam logic [3:0] LP_LAST = 4'(STABLE_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [10:0] r_sample;
   logic [3:0]  r_count;
   logic [3:0]  r_mask;
   logic [15:0] r_slots;
   logic        r_strobe;
   logic        r_err;
   logic        r_frame;
   logic [1:0]  r_idx;
   logic [3:0]  r_bcd;
   logic [15:0] r_value;

   logic [10:0] w_raw;
   logic        w_same;
   logic        w_onehot;
   logic        w_capture;
   logic [1:0]  w_idx;
   logic        w_legal;
   logic [3:0]  w_dec;
   logic [3:0]  w_idx_bit;
   logic [3:0]  w_mask_set;
   logic [15:0] w_new_slots;

   assign w_raw     = {dig_en, seg};
   assign w_same    = (w_raw == r_sample);
   assign w_onehot  = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
   // Capture only if this edge is the STABLE_CYCLES-th identical sample. If the
   // input changes on that same edge, w_same is low and nothing is captured.
   assign w_capture = w_onehot && w_same && (r_state == ST_SETTLE) && (r_count == LP_LAST);

   // Encode the one-hot digit select into an index.
   always_comb begin
      w_idx = 2'd0;
      case (dig_en)
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
   end

   // Decode the segment pattern to BCD and flag codes that are not digits.
   always_comb begin
      w_legal = 1'b1;
      w_dec   = 4'd0;
      case (seg)
         7'b1111110: w_dec = 4'd0;
         7'b0110000: w_dec = 4'd1;
         7'b1101101: w_dec = 4'd2;
         7'b1111001: w_dec = 4'd3;
         7'b0110011: w_dec = 4'd4;
         7'b1011011: w_dec = 4'd5;
         7'b1011111: w_dec = 4'd6;
         7'b1110000: w_dec = 4'd7;
         7'b1111111: w_dec = 4'd8;
         7'b1111011: w_dec = 4'd9;
         default:    w_legal = 1'b0;
      endcase
   end

   // Work out the mask and slot contents that a legal capture would produce.
   always_comb begin
      w_idx_bit   = 4'b0001 << w_idx;
      w_mask_set  = r_mask | w_idx_bit;
      w_new_slots = r_slots;
      w_new_slots[4*w_idx +: 4] = w_dec;
   end

   // Next-state logic. BLANK and SETTLE depend only on the raw input.
   // CAPTURED holds until the input changes.
   always_comb begin
      w_state_nxt = r_state;
      if (!w_onehot) begin
         w_state_nxt = ST_BLANK;
      end else if (!w_same) begin
         w_state_nxt = ST_SETTLE;
      end else if (w_capture) begin
         w_state_nxt = ST_CAPTURED;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_BLANK;
      else        r_state <= w_state_nxt;
   end

   // Stability tracking. Reload on any change, otherwise count up and saturate at 15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample <= 11'd0;
         r_count  <= 4'd0;
      end else if (!w_same) begin
         r_sample <= w_raw;
         r_count  <= 4'd1;
      end else if (r_count != 4'hF) begin
         r_count  <= r_count + 4'd1;
      end
   end

   // Capture path: pulse outputs, shadow slots, digit mask and frame assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_strobe <= 1'b0;
         r_err    <= 1'b0;
         r_frame  <= 1'b0;
         r_idx    <= 2'd0;
         r_bcd    <= 4'd0;
         r_mask   <= 4'd0;
         r_slots  <= 16'd0;
         r_value  <= 16'd0;
      end else begin
         r_strobe <= 1'b0;
         r_err    <= 1'b0;
         r_frame  <= 1'b0;
         if (w_capture) begin
            r_idx <= w_idx;
            if (w_legal) begin
               r_strobe <= 1'b1;
               r_bcd    <= w_dec;
               r_slots  <= w_new_slots;
               if (w_mask_set == 4'hF) begin
                  r_value <= w_new_slots;
                  r_frame <= 1'b1;
                  r_mask  <= 4'd0;
               end else begin
                  r_mask  <= w_mask_set;
               end
            end else begin
               r_err  <= 1'b1;
               r_bcd  <= 4'd0;
               r_mask <= r_mask & ~w_idx_bit;
            end
         end
      end
   end

   assign digit_strobe = r_strobe;
   assign code_err     = r_err;
   assign frame_valid  = r_frame;
   assign digit_idx    = r_idx;
   assign digit_bcd    = r_bcd;
   assign bcd_value    = r_value;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder. Directed scan sequences push their expected
// digit events into a queue. A negedge monitor pops one entry each time the
// DUT pulses digit_strobe or code_err and compares it field by field,
// including the cycle in which the pulse arrives.
module tb_seg7_scan_decoder;

   localparam int STABLE = 4;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic        digit_strobe;
   logic [1:0]  digit_idx;
   logic [3:0]  digit_bcd;
   logic        code_err;
   logic        frame_valid;
   logic [15:0] bcd_value;
   logic [1:0]  dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 0;
   // Entry layout: {cycle[31:0], frame_valid, code_err, idx[1:0], bcd[3:0], value[15:0]}
   logic [55:0] exp_q[$];

   seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .dig_en(dig_en),
      .digit_strobe(digit_strobe), .digit_idx(digit_idx), .digit_bcd(digit_bcd),
      .code_err(code_err), .frame_valid(frame_valid), .bcd_value(bcd_value),
      .dbg_state(dbg_state)
   );

   // Clock, plus a count of rising edges used to timestamp events.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 32'd1;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Drive one dwell, starting at a negedge. If ev is set, push the event that
   // should appear after edge STABLE of this dwell.
   task automatic dwell(input logic [3:0] de, input logic [6:0] sg, input int n,
                        input logic ev, input logic fv, input logic err,
                        input logic [1:0] idx, input logic [3:0] bcd, input logic [15:0] val);
      dig_en = de;
      seg    = sg;
      if (ev) exp_q.push_back({cyc + 32'(STABLE), fv, err, idx, bcd, val});
      repeat (n) @(negedge clk);
   endtask

   task automatic blank();
      dwell(4'b0000, 7'b0000000, 2, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0);
   endtask

   task automatic legal(input logic [3:0] de, input logic [6:0] sg, input logic [1:0] idx,
                        input logic [3:0] bcd, input logic fv, input logic [15:0] val);
      dwell(de, sg, 6, 1'b1, fv, 1'b0, idx, bcd, val);
      blank();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_strobe"}, 16'(digit_strobe), 16'h0);
      chk({tag, "_err"},    16'(code_err),     16'h0);
      chk({tag, "_frame"},  16'(frame_valid),  16'h0);
      chk({tag, "_idx"},    16'(digit_idx),    16'h0);
      chk({tag, "_bcd"},    16'(digit_bcd),    16'h0);
      chk({tag, "_value"},  bcd_value,         16'h0);
      chk({tag, "_state"},  16'(dbg_state),    16'h0);
   endtask

   // Monitor: every strobe or error pulse must match the head of the queue.
   always @(negedge clk) begin
      logic [55:0] exp_e;
      logic [55:0] got_e;
      if (rst_n) begin
         if (digit_strobe || code_err) begin
            got_e = {cyc, frame_valid, code_err, digit_idx, digit_bcd, bcd_value};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event got cyc=%0d fv=%b err=%b idx=%0d bcd=%0d val=%h",
                        cyc, frame_valid, code_err, digit_idx, digit_bcd, bcd_value);
            end else begin
               exp_e = exp_q.pop_front();
               if (got_e !== exp_e || (digit_strobe && code_err)) begin
                  errors++;
                  $display("FAIL digit_event got cyc=%0d fv=%b strobe=%b err=%b idx=%0d bcd=%0d val=%h exp cyc=%0d fv=%b err=%b idx=%0d bcd=%0d val=%h",
                           cyc, frame_valid, digit_strobe, code_err, digit_idx, digit_bcd, bcd_value,
                           exp_e[55:24], exp_e[23], exp_e[22], exp_e[21:20], exp_e[19:16], exp_e[15:0]);
               end
            end
         end else if (frame_valid) begin
            checks++;
            errors++;
            $display("FAIL lone_frame_valid got cyc=%0d val=%h exp no pulse", cyc, bcd_value);
         end
      end
   end

   // Stimulus.
   initial begin
      rst_n  = 1'b0;
      dig_en = 4'd0;
      seg    = 7'd0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single digit held for 10 cycles gives exactly one strobe.
      dwell(4'b0001, 7'b1101101, 10, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2, 16'h0000);
      blank();
      // Blank pattern on digit 2 is an illegal code.
      dwell(4'b0100, 7'b0000000, 6, 1'b1, 1'b0, 1'b1, 2'd2, 4'd0, 16'h0000);
      blank();
      // Pattern toggling every 3 cycles never settles.
      for (int i = 0; i < 3; i++) begin
         dwell(4'b0010, 7'b1111110, 3, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0);
         dwell(4'b0010, 7'b0110000, 3, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0);
      end
      // A multi-hot select never captures.
      dwell(4'b0011, 7'b1111111, 8, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0);
      blank();

      // Full scan 1,9,0,7. Digit 0 overwrites the earlier 2.
      legal(4'b0001, 7'b0110000, 2'd0, 4'd1, 1'b0, 16'h0000);
      legal(4'b0010, 7'b1111011, 2'd1, 4'd9, 1'b0, 16'h0000);
      legal(4'b0100, 7'b1111110, 2'd2, 4'd0, 1'b0, 16'h0000);
      legal(4'b1000, 7'b1110000, 2'd3, 4'd7, 1'b1, 16'h7091);

      // Digit 1 recaptured (5 then 8) before the frame completes.
      legal(4'b0010, 7'b1011011, 2'd1, 4'd5, 1'b0, 16'h7091);
      legal(4'b0010, 7'b1111111, 2'd1, 4'd8, 1'b0, 16'h7091);
      legal(4'b0001, 7'b0110000, 2'd0, 4'd1, 1'b0, 16'h7091);
      legal(4'b0100, 7'b1101101, 2'd2, 4'd2, 1'b0, 16'h7091);
      legal(4'b1000, 7'b1111001, 2'd3, 4'd3, 1'b1, 16'h3281);

      // Half frame, then an asynchronous reset during the dwell of digit 2.
      legal(4'b0001, 7'b1011111, 2'd0, 4'd6, 1'b0, 16'h3281);
      legal(4'b0010, 7'b0110011, 2'd1, 4'd4, 1'b0, 16'h3281);
      dwell(4'b0100, 7'b1111011, 2, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 16'h0);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_reset");
      @(negedge clk);
      dig_en = 4'd0;
      seg    = 7'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh full scan of 3s.
      legal(4'b0001, 7'b1111001, 2'd0, 4'd3, 1'b0, 16'h0000);
      legal(4'b0010, 7'b1111001, 2'd1, 4'd3, 1'b0, 16'h0000);
      legal(4'b0100, 7'b1111001, 2'd2, 4'd3, 1'b0, 16'h0000);
      legal(4'b1000, 7'b1111001, 2'd3, 4'd3, 1'b1, 16'h3333);

      repeat (4) @(negedge clk);
      chk("pending_events", 16'(exp_q.size()), 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical input samples required before a digit is accepted; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 seg  input  7  segment pattern from multiplexed display bus, active-high, seg[6]=a ... seg[0]=g.
REQ-005 dig_en  input  4  digit select, active-high, one-hot when a digit is driven; dig_en[i] selects digit i.
REQ-006 digit_strobe  output  1  one-cycle pulse: valid digit accepted.
REQ-007 digit_idx  output  2  index of accepted digit; valid with digit_strobe or code_err.
REQ-008 digit_bcd  output  4  decoded BCD of accepted digit; valid with digit_strobe.
REQ-009 code_err  output  1  one-cycle pulse: stable pattern is not a legal digit code.
REQ-010 frame_valid  output  1  one-cycle pulse: bcd_value updated with a complete 4-digit frame.
REQ-011 bcd_value  output  16  last complete frame; digit i at bits [4i+3:4i].

Function
REQ-012 Decode table (seg -> bcd): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; every other pattern, including 0000000, is illegal.
REQ-013 Sample register holds last {dig_en, seg}; each edge: raw equals sample -> counter increments (saturate at 15); else sample <= raw, counter <= 1.
REQ-014 States: BLANK, SETTLE, CAPTURED.
REQ-015 BLANK: entered when raw dig_en is not one-hot (zero or multi-hot); counter activity continues, no capture possible.
REQ-016 Any edge where raw {dig_en, seg} differs from sample and raw dig_en is one-hot -> SETTLE.
REQ-017 SETTLE: at the edge where counter becomes STABLE_CYCLES -> CAPTURED; capture evaluated on the sampled pattern.
REQ-018 CAPTURED: hold until raw input changes; no further strobe for same dwell regardless of dwell length.
REQ-019 Latency: input held constant from before edge 1 -> digit_strobe/code_err high in cycle following edge STABLE_CYCLES, low otherwise.
REQ-020 Legal capture: digit_strobe=1, digit_idx=encoded dig_en, digit_bcd=decoded value, shadow slot[idx] written, mask bit[idx] set.
REQ-021 Illegal capture: code_err=1, digit_idx valid, digit_bcd=0, slot unchanged, mask bit[idx] cleared.
REQ-022 Recapture of slot already in mask before frame completes: slot overwritten (latest wins), mask unchanged, no frame_valid.
REQ-023 Legal capture completing mask=1111: same edge bcd_value <= all four slots (including the new digit), frame_valid=1 with digit_strobe, mask <= 0000.
REQ-024 bcd_value changes only per REQ-023; digit_strobe and code_err never both high.
REQ-025 Input change on same edge counter would reach STABLE_CYCLES: no capture; new sample, counter=1.

Reset
REQ-026 rst_n low: immediately state=BLANK, counter=0, sample=0, mask=0000, shadow slots=0, all outputs 0 (bcd_value=16'h0000).
REQ-027 Reset mid-dwell or mid-frame discards partial digits; after release, STABLE_CYCLES fresh stable samples required for first capture.

Verification
REQ-028 dig_en=0001, seg=1101101 held 10 cycles, STABLE_CYCLES=4 -> one digit_strobe after edge 4, digit_idx=0, digit_bcd=2; no further pulses.
REQ-029 Scan digits 0..3 with codes 1,9,0,7 (dwell 6, blank 2 between) -> frame_valid with last strobe, bcd_value=16'h7091.
REQ-030 dig_en=0100, seg=0000000 held 6 cycles -> code_err after edge 4, digit_idx=2, mask bit 2 clear, no frame_valid.
REQ-031 Pattern toggles every 3 cycles (STABLE_CYCLES=4) -> zero strobes; dig_en=0011 held 8 cycles -> zero strobes, zero errors.
REQ-032 Frame half-complete (digits 0,1), rst_n pulsed low mid-dwell of digit 2 -> outputs 0 asynchronously; full new scan 3,3,3,3 required -> bcd_value=16'h3333.
REQ-033 Digit 1 captured as 5 then as 8 before digits 0,2,3 complete (values 1,2,3) -> bcd_value=16'h3281, single frame_valid.
